// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath.
// It steps each instruction through fetch, decode, execute, memory and
// writeback (3-5 cycles) and drives every datapath select and enable.
// The FSM waits in FETCH, MEMRD and MEMWR until mem_ready_i is high.
module multicycle_ctrl #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [OP_W-1:0] instr_op_i,
  input  logic            mem_ready_i,
  output logic            PCWrite_o,
  output logic            PCWriteCond_o,
  output logic            IorD_o,
  output logic            MemRead_o,
  output logic            MemWrite_o,
  output logic            IRWrite_o,
  output logic            MemtoReg_o,
  output logic            RegDst_o,
  output logic            RegWrite_o,
  output logic            ALUSrcA_o,
  output logic [1:0]      ALUSrcB_o,
  output logic [2:0]      ALU_op_o,
  output logic [1:0]      PCSource_o,
  output logic            instr_done_o,
  output logic            trap_o,
  output logic [ST_W-1:0] state_o
);

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = ST_W'(0),
    S_DECODE = ST_W'(1),
    S_MEMADR = ST_W'(2),
    S_MEMRD  = ST_W'(3),
    S_MEMWB  = ST_W'(4),
    S_MEMWR  = ST_W'(5),
    S_RTEX   = ST_W'(6),
    S_RTWB   = ST_W'(7),
    S_BEQ    = ST_W'(8),
    S_IMMEX  = ST_W'(9),
    S_IMMWB  = ST_W'(10),
    S_JUMP   = ST_W'(11),
    S_TRAP   = ST_W'(12)
  } state_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(9);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

  localparam logic [2:0] ALU_ADD  = 3'd2;
  localparam logic [2:0] ALU_RTYP = 3'd4;
  localparam logic [2:0] ALU_SUB  = 3'd5;
  localparam logic [2:0] ALU_SLTU = 3'd7;

  state_t state_reg;
  state_t state_next;

  assign state_o = state_reg;

  // State register; reset drops any in-flight instruction back to FETCH.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state sequencing; the opcode is only looked at in DECODE, MEMADR and IMMEX.
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op_i)
          OP_RTYPE:          state_next = S_RTEX;
          OP_BEQ:            state_next = S_BEQ;
          OP_ADDI, OP_SLTIU: state_next = S_IMMEX;
          OP_LW, OP_SW:      state_next = S_MEMADR;
          OP_J:              state_next = S_JUMP;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        // Anything other than lw/sw here means the IR changed underneath us.
        if (instr_op_i == OP_LW) begin
          state_next = S_MEMRD;
        end else if (instr_op_i == OP_SW) begin
          state_next = S_MEMWR;
        end else begin
          state_next = S_TRAP;
        end
      end
      S_MEMRD:  state_next = mem_ready_i ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = mem_ready_i ? S_FETCH : S_MEMWR;
      S_RTEX:   state_next = S_RTWB;
      S_RTWB:   state_next = S_FETCH;
      S_BEQ:    state_next = S_FETCH;
      S_IMMEX:  state_next = S_IMMWB;
      S_IMMWB:  state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  // Moore outputs decoded from the state, with ready gating in FETCH/MEMWR;
  // everything is held inert while reset is low.
  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'd0;
    ALU_op_o      = 3'd0;
    PCSource_o    = 2'd0;
    instr_done_o  = 1'b0;
    trap_o        = 1'b0;
    if (!rst_i) begin
      ALU_op_o = ALU_ADD;
    end else begin
      case (state_reg)
        S_FETCH: begin
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'd1;
          ALU_op_o  = ALU_ADD;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        S_DECODE: begin
          ALUSrcB_o = 2'd3;
          ALU_op_o  = ALU_ADD;
        end
        S_RTEX: begin
          ALUSrcA_o = 1'b1;
          ALU_op_o  = ALU_RTYP;
        end
        S_RTWB: begin
          RegDst_o     = 1'b1;
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        S_IMMEX: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'd2;
          ALU_op_o  = (instr_op_i == OP_SLTIU) ? ALU_SLTU : ALU_ADD;
        end
        S_IMMWB: begin
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA_o     = 1'b1;
          ALU_op_o      = ALU_SUB;
          PCWriteCond_o = 1'b1;
          PCSource_o    = 2'd1;
          instr_done_o  = 1'b1;
        end
        S_JUMP: begin
          PCWrite_o    = 1'b1;
          PCSource_o   = 2'd2;
          instr_done_o = 1'b1;
        end
        S_MEMADR: begin
          ALUSrcA_o = 1'b1;
          ALUSrcB_o = 2'd2;
          ALU_op_o  = ALU_ADD;
        end
        S_MEMRD: begin
          MemRead_o = 1'b1;
          IorD_o    = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg_o   = 1'b1;
          RegWrite_o   = 1'b1;
          instr_done_o = 1'b1;
        end
        S_MEMWR: begin
          MemWrite_o   = 1'b1;
          IorD_o       = 1'b1;
          instr_done_o = mem_ready_i;
        end
        S_TRAP: begin
          trap_o = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: a table of per-cycle vectors plus
// hand-written trap and mid-instruction reset sequences, checked through a
// scoreboard queue.
module tb_multicycle_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [5:0] instr_op_i = 6'd0;
  logic       mem_ready_i = 1'b0;
  logic       PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o;
  logic [1:0] ALUSrcB_o, PCSource_o;
  logic [2:0] ALU_op_o;
  logic       instr_done_o, trap_o;
  logic [3:0] state_o;

  // Clock generation, 10 time-unit period.
  always #5 clk_i = ~clk_i;

  multicycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .IRWrite_o(IRWrite_o),
    .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
    .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o),
    .PCSource_o(PCSource_o), .instr_done_o(instr_done_o), .trap_o(trap_o),
    .state_o(state_o)
  );

  // Output word order:
  // {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
  //  RegWrite, ALUSrcA, ALUSrcB[1:0], ALU_op[2:0], PCSource[1:0], instr_done, trap}
  logic [18:0] obs;
  assign obs = {PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
                MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALU_op_o,
                PCSource_o, instr_done_o, trap_o};

  localparam logic [18:0] E_RST    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd2,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_FWAIT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd1,3'd2,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_FRDY   = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'd1,3'd2,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd3,3'd2,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_RTEX   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd4,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_RTWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,3'd0,2'd0,1'b1,1'b0};
  localparam logic [18:0] E_IMMADD = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd2,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_IMMSLT = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd7,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_IMMWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,3'd0,2'd0,1'b1,1'b0};
  localparam logic [18:0] E_BEQ    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd0,3'd5,2'd1,1'b1,1'b0};
  localparam logic [18:0] E_JUMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,2'd2,1'b1,1'b0};
  localparam logic [18:0] E_MADR   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd2,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_MRD    = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'd0,3'd0,2'd0,1'b1,1'b0};
  localparam logic [18:0] E_MWRW   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,1'b0};
  localparam logic [18:0] E_MWRR   = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b1,1'b0};
  localparam logic [18:0] E_TRAP   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,1'b1};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [18:0] out;
  } vec_t;

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [18:0] out;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                     input logic [3:0] st, input logic [18:0] out);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.out = out;
    vecs.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic check_one();
    exp_t e;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expectation queued for state=%0d out=%h", state_o, obs);
    end else begin
      e = sb.pop_front();
      if (state_o !== e.st || obs !== e.out) begin
        n_bad++;
        $display("FAIL vec%0d: got state=%0d out=%h, expected state=%0d out=%h",
                 e.id, state_o, obs, e.st, e.out);
      end else begin
        $display("vec%0d ok: state=%0d out=%h", e.id, state_o, obs);
      end
    end
  endtask

  // One cycle: drive just after the rising edge, queue the expectation,
  // sample on the falling edge.
  task automatic step(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [18:0] out);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_i = rst;
    instr_op_i = op;
    mem_ready_i = rdy;
    e.id = n_vec; e.st = st; e.out = out;
    sb.push_back(e);
    n_vec++;
    @(negedge clk_i);
    check_one();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held across edges, then release with memory stalling fetch.
    add(0, 6'd0,  1, 4'd0,  E_RST);
    add(0, 6'd35, 1, 4'd0,  E_RST);
    add(0, 6'd43, 0, 4'd0,  E_RST);
    add(1, 6'd0,  0, 4'd0,  E_FWAIT);
    // R-type, ready tied high.
    add(1, 6'd0,  1, 4'd0,  E_FRDY);
    add(1, 6'd0,  1, 4'd1,  E_DEC);
    add(1, 6'd0,  1, 4'd6,  E_RTEX);
    add(1, 6'd0,  1, 4'd7,  E_RTWB);
    // lw with two stall cycles in MEMRD.
    add(1, 6'd35, 1, 4'd0,  E_FRDY);
    add(1, 6'd35, 1, 4'd1,  E_DEC);
    add(1, 6'd35, 1, 4'd2,  E_MADR);
    add(1, 6'd35, 0, 4'd3,  E_MRD);
    add(1, 6'd35, 0, 4'd3,  E_MRD);
    add(1, 6'd35, 1, 4'd3,  E_MRD);
    add(1, 6'd35, 1, 4'd4,  E_MWB);
    // sw with one fetch stall and one write stall.
    add(1, 6'd43, 0, 4'd0,  E_FWAIT);
    add(1, 6'd43, 1, 4'd0,  E_FRDY);
    add(1, 6'd43, 1, 4'd1,  E_DEC);
    add(1, 6'd43, 1, 4'd2,  E_MADR);
    add(1, 6'd43, 0, 4'd5,  E_MWRW);
    add(1, 6'd43, 1, 4'd5,  E_MWRR);
    // beq, addi, sltiu, j back to back.
    add(1, 6'd4,  1, 4'd0,  E_FRDY);
    add(1, 6'd4,  1, 4'd1,  E_DEC);
    add(1, 6'd4,  1, 4'd8,  E_BEQ);
    add(1, 6'd8,  1, 4'd0,  E_FRDY);
    add(1, 6'd8,  1, 4'd1,  E_DEC);
    add(1, 6'd8,  1, 4'd9,  E_IMMADD);
    add(1, 6'd8,  1, 4'd10, E_IMMWB);
    add(1, 6'd9,  1, 4'd0,  E_FRDY);
    add(1, 6'd9,  1, 4'd1,  E_DEC);
    add(1, 6'd9,  1, 4'd9,  E_IMMSLT);
    add(1, 6'd9,  1, 4'd10, E_IMMWB);
    add(1, 6'd2,  1, 4'd0,  E_FRDY);
    add(1, 6'd2,  1, 4'd1,  E_DEC);
    add(1, 6'd2,  1, 4'd11, E_JUMP);
    add(1, 6'd2,  0, 4'd0,  E_FWAIT);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].out);
    end

    // Illegal opcode: TRAP absorbs whatever the inputs do.
    step(1, 6'd63, 1, 4'd0, E_FRDY);
    step(1, 6'd63, 1, 4'd1, E_DEC);
    for (int k = 0; k < 10; k++) begin
      step(1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 4'd12, E_TRAP);
    end
    step(0, 6'd0,  1, 4'd0, E_RST);

    // lw interrupted by reset while stalled in MEMRD.
    step(1, 6'd35, 1, 4'd0, E_FRDY);
    step(1, 6'd35, 1, 4'd1, E_DEC);
    step(1, 6'd35, 1, 4'd2, E_MADR);
    step(1, 6'd35, 0, 4'd3, E_MRD);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    n_vec++;
    if (state_o !== 4'd0 || MemRead_o !== 1'b0 || RegWrite_o !== 1'b0 || obs !== E_RST) begin
      n_bad++;
      $display("FAIL async_reset_mid_memrd: got state=%0d MemRead=%0b RegWrite=%0b out=%h, expected state=0 MemRead=0 RegWrite=0 out=%h",
               state_o, MemRead_o, RegWrite_o, obs, E_RST);
    end else begin
      $display("vec%0d ok: async reset mid-MEMRD state=%0d out=%h", n_vec - 1, state_o, obs);
    end
    step(0, 6'd35, 1, 4'd0, E_RST);
    // Clean lw after the abandoned one.
    step(1, 6'd35, 1, 4'd0, E_FRDY);
    step(1, 6'd35, 1, 4'd1, E_DEC);
    step(1, 6'd35, 1, 4'd2, E_MADR);
    step(1, 6'd35, 1, 4'd3, E_MRD);
    step(1, 6'd35, 1, 4'd4, E_MWB);
    step(1, 6'd0,  0, 4'd0, E_FWAIT);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle MIPS datapath. It replaces the single-cycle combinational opcode decoder.
- Sequences fetch/decode/execute/memory/writeback over 3-5 cycles per instruction.
- Drives every datapath mux select and write enable, and stalls on a memory-ready handshake.
- Sits between the instruction register opcode field and the shared PC/IR/register-file/ALU/memory datapath.

Parameters:
- OP_W, 6, opcode width.
- ST_W, 4, state register width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- instr_op_i  in  6  opcode from IR[31:26]; valid from DECODE onward.
- mem_ready_i  in  1  memory access completes this cycle.
- PCWrite_o  out  1  unconditional PC load.
- PCWriteCond_o  out  1  PC load if ALU zero.
- IorD_o  out  1  0 = memory address from PC, 1 = from ALUOut.
- MemRead_o  out  1  memory read request.
- MemWrite_o  out  1  memory write request.
- IRWrite_o  out  1  IR load.
- MemtoReg_o  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst_o  out  1  destination: 0 = rt, 1 = rd.
- RegWrite_o  out  1  register file write.
- ALUSrcA_o  out  1  0 = PC, 1 = rs.
- ALUSrcB_o  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2.
- ALU_op_o  out  3  2 = add, 5 = sub, 7 = set-less-than-unsigned, 4 = R-type (funct decides).
- PCSource_o  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target.
- instr_done_o  out  1  one-cycle pulse on the final cycle of each instruction.
- trap_o  out  1  sticky illegal-opcode flag.
- state_o  out  4  current state, debug only.

Behaviour:
- Moore FSM, 4-bit state register; the next state is registered on the clk_i rising edge.
- Outputs are combinational from the state register, plus mem_ready_i gating in the memory states.
- Every output not listed for a state is 0.
- Reset (rst_i=0, asynchronous): state = FETCH, trap_o = 0. All write/read enables are forced 0 while reset is asserted. ALU_op_o = 2 and all selects are 0.
- Reset mid-instruction abandons it; no partial writes after reset assertion.
- States and outputs:
- FETCH(0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALU_op=2, PCSource=0; IRWrite=PCWrite=mem_ready_i. Stay until mem_ready_i=1, then DECODE.
- DECODE(1): ALUSrcA=0, ALUSrcB=3, ALU_op=2 (branch target into ALUOut). Next state by opcode:
- 0 -> RTEX.
- 4 -> BEQ.
- 8 or 9 -> IMMEX.
- 35 or 43 -> MEMADR.
- 2 -> JUMP.
- other -> TRAP.
- RTEX(6): ALUSrcA=1, ALUSrcB=0, ALU_op=4 -> RTWB.
- RTWB(7): RegDst=1, RegWrite=1, MemtoReg=0, instr_done -> FETCH.
- IMMEX(9): ALUSrcA=1, ALUSrcB=2, ALU_op=2 for opcode 8, 7 for opcode 9 -> IMMWB.
- IMMWB(10): RegDst=0, RegWrite=1, MemtoReg=0, instr_done -> FETCH.
- BEQ(8): ALUSrcA=1, ALUSrcB=0, ALU_op=5, PCWriteCond=1, PCSource=1, instr_done -> FETCH.
- JUMP(11): PCWrite=1, PCSource=2, instr_done -> FETCH.
- MEMADR(2): ALUSrcA=1, ALUSrcB=2, ALU_op=2. Next is MEMRD for opcode 35, MEMWR for opcode 43.
- MEMRD(3): MemRead=1, IorD=1. Wait for mem_ready_i, then MEMWB.
- MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1, instr_done -> FETCH.
- MEMWR(5): MemWrite=1, IorD=1. Wait for mem_ready_i; assert instr_done on the ready cycle -> FETCH.
- TRAP(12): trap_o=1 and all enables 0. Absorbing state; only reset exits.
- Unused state encodings (13-15) go to FETCH on the next edge.
- instr_op_i is sampled only in DECODE, MEMADR and IMMEX. The IR is stable there because IRWrite=0 outside FETCH.
- Latencies with mem_ready_i tied to 1:
- 3 cycles: beq, j.
- 4 cycles: R-type, addi, sltiu, sw.
- 5 cycles: lw.
- Each mem_ready_i=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.

Test Plan:
- Hold rst_i=0 across edges: state_o=0, all enables 0; release -> FETCH with MemRead_o=1.
- mem_ready_i=1, opcode 0: states 0,1,6,7,0; RegWrite_o=1 and RegDst_o=1 only in state 7; instr_done pulse at cycle 4.
- Opcode 35 with mem_ready_i low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0; MemtoReg_o=1 with RegWrite_o=1 in state 4.
- Opcode 43: MemWrite_o=1, IorD_o=1 in state 5; RegWrite_o stays 0 throughout.
- Opcodes 4, 8, 9, 2 in sequence:
- Opcode 4: ALU_op_o=5 and PCWriteCond_o=1 in BEQ.
- Opcode 8: ALU_op_o=2 in IMMEX.
- Opcode 9: ALU_op_o=7 in IMMEX.
- Opcode 2: PCSource_o=2 with PCWrite_o=1 in JUMP.
- Opcode 63: TRAP, trap_o=1 held for 10 cycles, all enables 0. Then pulse rst_i low mid-MEMRD on a later lw: immediate return to state 0 with no MemRead_o or RegWrite_o glitch.
